// File: rtl/rx_frame_gen_proc.sv
// rx_frame_gen_proc: DCFEB receive frame processor (delineation, CRC/length checks, status; optional stats via RX_FRAME_STATS_EN)
module rx_frame_gen_proc #(
    parameter int MAX_WORDS = 812,
    parameter int MIN_WORDS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [15:0]      RXDATA,
    input  logic [1:0]       RX_IS_K,
    input  logic [1:0]       RXDISPERR,
    input  logic [1:0]       RXNOTINTABLE,
    input  logic             FF_AF,
    input  logic             CNT_CLR,
    output logic [15:0]      FRM_DATA,
    output logic             FRM_DATA_VALID,
    output logic             STAT_VALID,
    output logic [4:0]       STAT,
    output logic [11:0]      STAT_LEN,
    output logic             GOOD_CRC,
    output logic [CNT_W-1:0] PKT_CNT,
    output logic [CNT_W-1:0] CRC_ERR_CNT,
    output logic [CNT_W-1:0] DROP_CNT
);

    typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, CHK} state_t;

    localparam logic [11:0] MAX_L = 12'(MAX_WORDS);
    localparam logic [11:0] MIN_L = 12'(MIN_WORDS);

    state_t      state;
    logic [15:0] rx_d;
    logic [1:0]  rx_k;
    logic        rx_err;
    logic        ff_q;
    logic [1:0]  pre_idx;
    logic [15:0] hold;
    logic        hold_v;
    logic [15:0] crc;
    logic [11:0] cnt;
    logic [4:0]  flags;
    logic        is_sop;
    logic        is_eop;
    logic        bad_in;
    logic        pre_ok;
    logic        short_pkt;
    logic        abort;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    assign is_sop    = rx_k == 2'b01 && rx_d == 16'h55FB;
    assign is_eop    = rx_k == 2'b11 && rx_d == 16'hF7FD;
    assign bad_in    = rx_err || (rx_k != 2'b00 && !is_eop);
    assign pre_ok    = !rx_err && rx_k == 2'b00 && rx_d == (pre_idx == 2'd2 ? 16'hD555 : 16'h5555);
    assign short_pkt = cnt < MIN_L;
    assign abort     = (state == PRE && !pre_ok) || (state == DATA && bad_in);

    // input stage: register the word with its flags and the FIFO almost-full level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_d   <= '0;
            rx_k   <= '0;
            rx_err <= 1'b0;
            ff_q   <= 1'b0;
        end else begin
            rx_d   <= RXDATA;
            rx_k   <= RX_IS_K;
            rx_err <= |RXDISPERR || |RXNOTINTABLE;
            ff_q   <= FF_AF;
        end
    end

    // packet FSM: preamble check, one-word hold for CRC stripping, forwarding and status
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            pre_idx        <= '0;
            hold           <= '0;
            hold_v         <= 1'b0;
            crc            <= 16'hFFFF;
            cnt            <= '0;
            flags          <= '0;
            FRM_DATA       <= '0;
            FRM_DATA_VALID <= 1'b0;
            STAT_VALID     <= 1'b0;
            STAT           <= '0;
            STAT_LEN       <= '0;
            GOOD_CRC       <= 1'b1;
        end else begin
            FRM_DATA_VALID <= 1'b0;
            STAT_VALID     <= 1'b0;
            if (abort) begin
                STAT_VALID <= 1'b1;
                STAT       <= 5'b01000;
                STAT_LEN   <= cnt;
                GOOD_CRC   <= 1'b1;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE, CHK: begin
                        if (state == CHK) begin
                            STAT_VALID <= 1'b1;
                            STAT       <= flags;
                            STAT_LEN   <= cnt;
                            GOOD_CRC   <= !flags[0];
                        end
                        state <= IDLE;
                        if (is_sop) begin
                            state   <= ff_q ? DROP : PRE;
                            flags   <= ff_q ? 5'b10000 : 5'b00000;
                            pre_idx <= '0;
                            hold_v  <= 1'b0;
                            crc     <= 16'hFFFF;
                            cnt     <= '0;
                        end
                    end
                    PRE: begin
                        pre_idx <= pre_idx + 2'd1;
                        if (pre_idx == 2'd2) state <= DATA;
                    end
                    DATA: begin
                        if (is_eop) begin
                            flags <= {3'b000, short_pkt, !short_pkt && crc != hold};
                            state <= CHK;
                        end else begin
                            hold   <= rx_d;
                            hold_v <= 1'b1;
                            if (hold_v && cnt == MAX_L) begin
                                flags <= 5'b00100;
                                state <= DROP;
                            end else if (hold_v) begin
                                FRM_DATA       <= hold;
                                FRM_DATA_VALID <= 1'b1;
                                cnt            <= cnt + 12'd1;
                                crc            <= crc_step(crc, hold);
                            end
                        end
                    end
                    DROP: if (is_eop) state <= CHK;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RX_FRAME_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // saturating link statistics, clear wins over a same-cycle increment
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || CNT_CLR) begin
            PKT_CNT     <= '0;
            CRC_ERR_CNT <= '0;
            DROP_CNT    <= '0;
        end else if (STAT_VALID) begin
            if (STAT == 5'b00000 && !(&PKT_CNT)) PKT_CNT <= PKT_CNT + CNT_ONE;
            if (STAT[0] && !(&CRC_ERR_CNT)) CRC_ERR_CNT <= CRC_ERR_CNT + CNT_ONE;
            if (STAT[4] && !(&DROP_CNT)) DROP_CNT <= DROP_CNT + CNT_ONE;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = CNT_CLR;
    assign PKT_CNT        = '0;
    assign CRC_ERR_CNT    = '0;
    assign DROP_CNT       = '0;
`endif

endmodule

// File: tb/tb_rx_frame_gen_proc.sv
// tb_rx_frame_gen_proc: directed bench for rx_frame_gen_proc (MAX_WORDS=8, MIN_WORDS=4, CNT_W=2)
module tb_rx_frame_gen_proc;

`ifdef RX_FRAME_STATS_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] RXDATA = '0;
    logic [1:0]  RX_IS_K = '0;
    logic [1:0]  RXDISPERR = '0;
    logic [1:0]  RXNOTINTABLE = '0;
    logic        FF_AF = 1'b0;
    logic        CNT_CLR = 1'b0;
    logic [15:0] FRM_DATA;
    logic        FRM_DATA_VALID;
    logic        STAT_VALID;
    logic [4:0]  STAT;
    logic [11:0] STAT_LEN;
    logic        GOOD_CRC;
    logic [1:0]  PKT_CNT;
    logic [1:0]  CRC_ERR_CNT;
    logic [1:0]  DROP_CNT;

    rx_frame_gen_proc #(.MAX_WORDS(8), .MIN_WORDS(4), .CNT_W(2)) dut (
        .CLK(CLK), .RST(RST), .RXDATA(RXDATA), .RX_IS_K(RX_IS_K), .RXDISPERR(RXDISPERR),
        .RXNOTINTABLE(RXNOTINTABLE), .FF_AF(FF_AF), .CNT_CLR(CNT_CLR), .FRM_DATA(FRM_DATA),
        .FRM_DATA_VALID(FRM_DATA_VALID), .STAT_VALID(STAT_VALID), .STAT(STAT), .STAT_LEN(STAT_LEN),
        .GOOD_CRC(GOOD_CRC), .PKT_CNT(PKT_CNT), .CRC_ERR_CNT(CRC_ERR_CNT), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  st;
        logic [11:0] len;
        logic        g;
        int          cyc;
    } st_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          both = 0;
    int          w0cyc, ecyc, acyc, sc;
    logic [15:0] beats[$];
    int          bcyc[$];
    st_t         sq[$];

    always @(posedge CLK) cyc <= cyc + 1;

    // observe outputs on the falling edge
    always @(negedge CLK) begin
        if (FRM_DATA_VALID) begin
            beats.push_back(FRM_DATA);
            bcyc.push_back(cyc);
        end
        if (STAT_VALID) sq.push_back('{STAT, STAT_LEN, GOOD_CRC, cyc});
        if (FRM_DATA_VALID && STAT_VALID) both++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    // byte-at-a-time CRC-16/CCITT-FALSE reference
    function automatic logic [15:0] crc_w(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        logic [7:0]  b;
        r = c;
        for (int j = 0; j < 2; j++) begin
            b = (j == 0) ? w[15:8] : w[7:0];
            r = r ^ {b, 8'h00};
            for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [15:0] d, input logic [1:0] de, input logic af);
        @(negedge CLK);
        RX_IS_K = k;
        RXDATA = d;
        RXDISPERR = de;
        RXNOTINTABLE = 2'b00;
        FF_AF = af;
    endtask

    task automatic idle(input int n);
        repeat (n) send(2'b01, 16'h50BC, 2'b00, 1'b0);
    endtask

    task automatic preamble(input logic af);
        send(2'b01, 16'h55FB, 2'b00, af);
        send(2'b00, 16'h5555, 2'b00, 1'b0);
        send(2'b00, 16'h5555, 2'b00, 1'b0);
        send(2'b00, 16'hD555, 2'b00, 1'b0);
    endtask

    task automatic pkt(input int n, input logic [15:0] base, input logic [15:0] cx, input int err_at, input logic af);
        logic [15:0] c;
        logic [15:0] w;
        c = 16'hFFFF;
        preamble(af);
        for (int i = 0; i < n; i++) begin
            w = base + 16'(i);
            c = crc_w(c, w);
            send(2'b00, w, (i == err_at) ? 2'b01 : 2'b00, 1'b0);
            if (i == 0) w0cyc = cyc;
            if (i == err_at) acyc = cyc;
        end
        send(2'b00, c ^ cx, 2'b00, 1'b0);
        send(2'b11, 16'hF7FD, 2'b00, 1'b0);
        ecyc = cyc;
    endtask

    task automatic wait_stat(input int n);
        int t;
        t = 0;
        while (sq.size() < n && t < 80) begin
            @(negedge CLK);
            t++;
        end
        chk("stat_arrived", sq.size() >= n, 1);
    endtask

    task automatic chk_stat(input string tag, input logic [4:0] st, input int len, input logic g, output int c);
        st_t e;
        e = '{5'h1F, 12'hFFF, 1'bx, -100};
        if (sq.size() > 0) e = sq.pop_front();
        chk(tag, e.st, st);
        chk(tag, e.len, len);
        chk(tag, e.g, g);
        c = e.cyc;
    endtask

    task automatic chk_beats(input string tag, input int n, input logic [15:0] base);
        chk(tag, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) chk(tag, beats[i], base + 16'(i));
        beats.delete();
        bcyc.delete();
    endtask

    task automatic chk_cnt(input string tag, input int p, input int c, input int d);
        chk(tag, PKT_CNT, S ? p : 0);
        chk(tag, CRC_ERR_CNT, S ? c : 0);
        chk(tag, DROP_CNT, S ? d : 0);
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, FRM_DATA, 0);
        chk(tag, FRM_DATA_VALID, 0);
        chk(tag, STAT_VALID, 0);
        chk(tag, STAT, 0);
        chk(tag, STAT_LEN, 0);
        chk(tag, GOOD_CRC, 1);
        chk_cnt(tag, 0, 0, 0);
    endtask

    initial begin
        int t;
        repeat (2) @(negedge CLK);
        chk_reset("reset");
        RST = 1'b0;
        idle(3);

        pkt(4, 16'h0001, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk("good_latency", bcyc.size() > 0 ? bcyc[0] - w0cyc : -1, 3);
        chk_stat("good", 5'b00000, 4, 1'b1, sc);
        chk("good_stat_latency", sc - ecyc, 3);
        chk("good_crc_level", GOOD_CRC, 1);
        chk_beats("good_beats", 4, 16'h0001);
        chk_cnt("good_cnt", 1, 0, 0);

        pkt(4, 16'h0001, 16'h0001, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("badcrc", 5'b00001, 4, 1'b0, sc);
        chk("badcrc_level", GOOD_CRC, 0);
        chk_beats("badcrc_beats", 4, 16'h0001);
        chk_cnt("badcrc_cnt", 1, 1, 0);

        pkt(6, 16'h0100, 16'h0000, -1, 1'b1);
        pkt(4, 16'h0200, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(2);
        idle(2);
        chk_stat("drop", 5'b10000, 0, 1'b1, sc);
        chk_stat("after_drop", 5'b00000, 4, 1'b1, sc);
        chk_beats("after_drop_beats", 4, 16'h0200);
        chk_cnt("drop_cnt", 2, 1, 1);

        pkt(8, 16'h0300, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("max_exact", 5'b00000, 8, 1'b1, sc);
        chk_beats("max_exact_beats", 8, 16'h0300);

        pkt(10, 16'h0400, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("too_long", 5'b00100, 8, 1'b1, sc);
        chk_beats("too_long_beats", 8, 16'h0400);

        pkt(2, 16'h0500, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("too_short", 5'b00010, 2, 1'b1, sc);
        chk_beats("too_short_beats", 2, 16'h0500);
        chk_cnt("len_cnt", 3, 1, 1);

        pkt(6, 16'h0600, 16'h0000, 3, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("disperr", 5'b01000, 2, 1'b1, sc);
        chk("disperr_latency", sc - acyc, 2);
        chk_beats("disperr_beats", 2, 16'h0600);
        pkt(4, 16'h0700, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("after_err", 5'b00000, 4, 1'b1, sc);
        chk_beats("after_err_beats", 4, 16'h0700);

        preamble(1'b0);
        send(2'b00, 16'h0801, 2'b00, 1'b0);
        send(2'b00, 16'h0802, 2'b00, 1'b0);
        pkt(4, 16'h0900, 16'h0000, -1, 1'b0);
        idle(8);
        chk("sop_in_data_count", sq.size(), 1);
        chk_stat("sop_in_data", 5'b01000, 1, 1'b1, sc);
        chk_beats("sop_in_data_beats", 1, 16'h0801);

        CNT_CLR = 1'b1;
        idle(1);
        CNT_CLR = 1'b0;
        idle(1);
        chk_cnt("clr", 0, 0, 0);
        for (int n = 0; n < 5; n++) begin
            pkt(4, 16'h1000, 16'h0000, -1, 1'b0);
            idle(2);
        end
        wait_stat(5);
        idle(2);
        for (int n = 0; n < 5; n++) chk_stat("five_good", 5'b00000, 4, 1'b1, sc);
        beats.delete();
        bcyc.delete();
        chk_cnt("saturate", 3, 0, 0);

        pkt(4, 16'h1100, 16'h0000, -1, 1'b0);
        idle(1);
        t = 0;
        while (!STAT_VALID && t < 20) begin
            @(negedge CLK);
            t++;
        end
        chk("clr_sync_seen", STAT_VALID, 1);
        CNT_CLR = 1'b1;
        @(negedge CLK);
        CNT_CLR = 1'b0;
        idle(2);
        chk_stat("clr_sync", 5'b00000, 4, 1'b1, sc);
        beats.delete();
        bcyc.delete();
        chk_cnt("clr_priority", 0, 0, 0);

        pkt(4, 16'h1200, 16'h0002, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("pre_reset_bad", 5'b00001, 4, 1'b0, sc);
        beats.delete();
        bcyc.delete();
        chk_cnt("pre_reset_cnt", 0, 1, 0);

        preamble(1'b0);
        for (int i = 0; i < 5; i++) send(2'b00, 16'h1300 + 16'(i), 2'b00, 1'b0);
        RST = 1'b1;
        #1;
        chk_reset("mid_reset");
        @(negedge CLK);
        RST = 1'b0;
        beats.delete();
        bcyc.delete();
        send(2'b00, 16'h1305, 2'b00, 1'b0);
        send(2'b00, 16'hABCD, 2'b00, 1'b0);
        send(2'b11, 16'hF7FD, 2'b00, 1'b0);
        idle(6);
        chk("mid_reset_no_stat", sq.size(), 0);
        chk("mid_reset_no_beats", beats.size(), 0);
        pkt(4, 16'h1400, 16'h0000, -1, 1'b0);
        idle(1);
        wait_stat(1);
        idle(2);
        chk_stat("post_reset", 5'b00000, 4, 1'b1, sc);
        chk_beats("post_reset_beats", 4, 16'h1400);
        chk_cnt("post_reset_cnt", 1, 0, 0);

        chk("no_overlap", both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_gen_proc.md
# rx_frame_gen_proc

Parametrised next-generation receive frame processor for DCFEB optical links on the ODMB. It sits between the 16-bit 8b/10b deserialiser interface and the per-DCFEB data FIFO. It delineates packets, strips the preamble and CRC trailer, forwards payload words, and checks both CRC and length bounds. Each packet ends with a per-packet status word, and optional saturating link-statistics counters can be compiled in.

## Interface
- MAX_WORDS, 812, maximum payload words per packet (excluding CRC); legal range 1..4095
- MIN_WORDS, 4, minimum payload words per packet; must be ≤ MAX_WORDS
- CNT_W, 16, width of statistics counters
- CLK  in  1  word clock, one 16-bit word per cycle
- RST  in  1  reset, asynchronous, active-high
- RXDATA  in  16  received word; byte [7:0] arrives first
- RX_IS_K  in  2  per-byte K-character flags
- RXDISPERR  in  2  per-byte disparity error
- RXNOTINTABLE  in  2  per-byte code violation
- FF_AF  in  1  downstream FIFO almost-full, sampled at SOP
- CNT_CLR  in  1  synchronous clear of statistics counters
- FRM_DATA  out  16  payload word
- FRM_DATA_VALID  out  1  FRM_DATA qualifier
- STAT_VALID  out  1  one-cycle end-of-packet status strobe
- STAT  out  5  status bits:
  - [0] bad_crc
  - [1] too_short
  - [2] too_long
  - [3] code_err
  - [4] dropped_ff
- STAT_LEN  out  12  payload words forwarded for the packet
- GOOD_CRC  out  1  level signal; CRC result of the last completed packet
- PKT_CNT, CRC_ERR_CNT, DROP_CNT  out  CNT_W each  statistics counters

## Operation
- Word 0 is SOP: RX_IS_K=2'b01, RXDATA={8'h55,8'hFB}.
- Preamble follows: 16'h5555, 16'h5555, then SOF word {8'hD5,8'h55}.
- Payload words follow, then one CRC word.
- Packet ends with the EOP word: RX_IS_K=2'b11, RXDATA={8'hF7,8'hFD}.
- States and transitions:
  - IDLE: idles and carrier extend are ignored. SOP → PRE, or → DROP if FF_AF=1. K27.7 in the upper byte is ignored.
  - PRE: expects the three preamble/SOF words in order. Any mismatch aborts.
  - DATA: each data word enters a one-word hold register. The previously held word is forwarded and folded into the CRC. EOP → check, then IDLE.
  - DROP: nothing is forwarded. Stays here until EOP, then issues status and returns to IDLE.
- Abort conditions: RXDISPERR/RXNOTINTABLE nonzero in PRE or DATA; any K character other than EOP in PRE or DATA; odd EOP (K29.7 in the upper byte); SOP in DATA.
- Abort response: STAT_VALID with code_err asserted, return to IDLE. A SOP that caused the abort is not restarted.
- CRC is CRC-16/CCITT-FALSE:
  - polynomial 0x1021, init 0xFFFF, no final XOR
  - data bit 15 first, covering payload words only
  - at EOP the computed CRC is compared to the held word
- bad_crc is set only when no other STAT bit is set.
- Length checks:
  - A payload word that would exceed MAX_WORDS sets too_long. State goes to DROP and earlier words stay forwarded.
  - A count below MIN_WORDS at EOP sets too_short.
- STAT_LEN equals the number of FRM_DATA_VALID beats for the packet; it is 0 for dropped packets.
- GOOD_CRC updates on every STAT_VALID as !STAT[0], so a packet with any other error reports GOOD_CRC=1.
- Reset values: all outputs 0 except GOOD_CRC=1; state IDLE; CRC register 0xFFFF.
- Reset mid-packet discards the packet with no status. The next SOP is accepted normally.

## Timing
- A payload word on RXDATA at cycle t appears on FRM_DATA at t+3, provided the following word is also data.
- EOP on RXDATA at cycle e gives STAT_VALID at e+3. STAT, STAT_LEN and GOOD_CRC are valid the same cycle.
- Abort detected on the input word at cycle a gives STAT_VALID at a+2.
- Back-to-back packets with zero idle words between EOP and SOP are supported.
- FRM_DATA_VALID and STAT_VALID are never asserted in the same cycle.

## Configuration
- RX_FRAME_STATS_EN defined: the three counters are compiled in, are unsigned, and saturate at all-ones.
  - PKT_CNT +1 on STAT_VALID with STAT==0.
  - CRC_ERR_CNT +1 on STAT[0].
  - DROP_CNT +1 on STAT[4].
  - CNT_CLR zeroes all three and takes priority over a same-cycle increment.
- RX_FRAME_STATS_EN undefined: no counter logic; the counter outputs are tied to 0 and CNT_CLR is ignored.

## Test plan
- Good packet, payload 0x0001..0x0004 plus the model-computed CRC → four beats 0x0001..0x0004, STAT=0, STAT_LEN=4, GOOD_CRC=1, PKT_CNT=1.
- Same packet with CRC XOR 0x0001 → STAT=5'b00001, GOOD_CRC=0, CRC_ERR_CNT=1, four beats still forwarded.
- FF_AF=1 at SOP, 6-word packet → zero beats, STAT=5'b10000, STAT_LEN=0, DROP_CNT=1. An immediately following packet with FF_AF=0 passes.
- MAX_WORDS=8 with a 10-word packet → eight beats, STAT=5'b00100, STAT_LEN=8. A 2-word packet gives STAT=5'b00010.
- RXDISPERR=2'b01 on payload word 3 → STAT_VALID two cycles later with STAT[3]=1, STAT_LEN=2. The following good packet is accepted.
- CNT_W=2 with five good packets → PKT_CNT saturates at 3. CNT_CLR coincident with STAT_VALID → counter 0. RST asserted mid-packet → all outputs at reset values, no STAT_VALID.
